// File: rtl/rf_pkg.sv
// Shared definitions for the register-file scheduler.
//   REG_COUNT / REG_ADDR_W / DATA_W : geometry of the 8x8 register file
//   STARVE_W                        : width of the store-data starvation counter
//   sched_state_t                   : scheduler FSM states
package rf_pkg;
  localparam int REG_COUNT  = 8;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);
  localparam int DATA_W     = 8;
  localparam int STARVE_W   = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } sched_state_t;
endpackage

// File: rtl/regfile_scheduler_if.sv
// Bundle of every bus the scheduler touches: issue request, operand
// delivery, ALU and load writeback, and the register-file port.
//   slave  : the scheduler's view
//   master : the view of issue, execute/LSU and the register file
//
// Handshakes (op_*, opd_*, alu_wb_*, mem_wb_*): a transfer happens on a
// rising edge where valid and ready are both high. A source holds valid and
// its payload stable until that transfer; ready may depend on valid.
interface regfile_scheduler_if;
  import rf_pkg::*;

  logic         op_valid;
  logic         op_ready;
  reg_addr_t    op_src1;
  reg_addr_t    op_src2;
  reg_addr_t    op_srcd;
  logic         op_use_srcd;

  logic         opd_valid;
  logic         opd_ready;
  data_t        opd_a;
  data_t        opd_b;
  data_t        opd_d;

  logic         alu_wb_valid;
  logic         alu_wb_ready;
  reg_addr_t    alu_wb_addr;
  data_t        alu_wb_data;

  logic         mem_wb_valid;
  logic         mem_wb_ready;
  reg_addr_t    mem_wb_addr;
  data_t        mem_wb_data;

  logic         rf_enable;
  reg_addr_t    rf_address1;
  reg_addr_t    rf_address2;
  reg_addr_t    rf_addressData;
  data_t        rf_dataIn;
  data_t        rf_data1;
  data_t        rf_data2;
  data_t        rf_dataMemory;

  sched_state_t dbg_state;

  modport slave (
    input  op_valid, op_src1, op_src2, op_srcd, op_use_srcd,
    output op_ready,
    output opd_valid, opd_a, opd_b, opd_d,
    input  opd_ready,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    output alu_wb_ready,
    input  mem_wb_valid, mem_wb_addr, mem_wb_data,
    output mem_wb_ready,
    output rf_enable, rf_address1, rf_address2, rf_addressData, rf_dataIn,
    input  rf_data1, rf_data2, rf_dataMemory,
    output dbg_state
  );

  modport master (
    output op_valid, op_src1, op_src2, op_srcd, op_use_srcd,
    input  op_ready,
    input  opd_valid, opd_a, opd_b, opd_d,
    output opd_ready,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  alu_wb_ready,
    output mem_wb_valid, mem_wb_addr, mem_wb_data,
    input  mem_wb_ready,
    input  rf_enable, rf_address1, rf_address2, rf_addressData, rf_dataIn,
    output rf_data1, rf_data2, rf_dataMemory,
    input  dbg_state
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational grant.
//   clk, rst : clock, asynchronous active-low reset
//   req[1:0] : request lines (0 = ALU, 1 = load unit)
//   gnt[1:0] : one-hot grant, a lone requester is always granted
// The pointer remembers who won last; on a tie the other requester wins.
// After reset requester 1 counts as the last winner, so requester 0 wins
// the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_hi_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_hi_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_hi_q <= 1'b1;
    else if (|gnt)   last_hi_q <= gnt[1];
  end
endmodule

// File: rtl/regfile_scheduler.sv
// Register-file scheduler: reads issue operands through the file's
// registered read ports and arbitrates ALU / load writeback onto the single
// write port, which shares its address with the store-data read port.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : issue, operand, writeback and register-file signals
//   STARVE_LIMIT : write grants tolerated while a store-data read waits
module regfile_scheduler
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_scheduler_if.slave  bus
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  sched_state_t        state, state_nxt;
  reg_addr_t           src1_q, src2_q, srcd_q, last_d_q;
  logic                use_srcd_q;
  logic                byp1_q, byp2_q;
  data_t               byp_data_q;
  data_t               opd_a_q, opd_b_q, opd_d_q;
  logic [STARVE_W-1:0] starve_q;

  logic       need_srcd, block_wr, any_wb, read_slot, sample;
  logic [1:0] req, gnt;
  reg_addr_t  addr_data;
  data_t      data_in;

  // addressData slot ownership: a waiting store-data read yields to writes
  // until the counter reaches the limit, then takes the slot for one cycle.
  assign need_srcd = (state == ST_READ) && use_srcd_q;
  assign block_wr  = need_srcd && (starve_q == LIMIT);
  assign any_wb    = bus.alu_wb_valid || bus.mem_wb_valid;
  assign req       = {bus.mem_wb_valid, bus.alu_wb_valid} & {2{rst && !block_wr}};
  assign read_slot = need_srcd && (block_wr || !any_wb);
  // All sources are sampled together, so READ only ends in a cycle where
  // the store-data read (if any) owns the slot.
  assign sample    = (state == ST_READ) && (!use_srcd_q || read_slot);

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  always_comb begin
    addr_data = last_d_q;
    data_in   = '0;
    if (gnt[0]) begin
      addr_data = bus.alu_wb_addr;
      data_in   = bus.alu_wb_data;
    end else if (gnt[1]) begin
      addr_data = bus.mem_wb_addr;
      data_in   = bus.mem_wb_data;
    end else if (need_srcd) begin
      addr_data = srcd_q;
    end
  end

  assign bus.rf_enable      = |gnt;
  assign bus.alu_wb_ready   = gnt[0];
  assign bus.mem_wb_ready   = gnt[1];
  assign bus.rf_addressData = addr_data;
  assign bus.rf_dataIn      = data_in;
  // The source registers only change on acceptance, so the read addresses
  // naturally hold their last value outside READ.
  assign bus.rf_address1    = src1_q;
  assign bus.rf_address2    = src2_q;
  assign bus.op_ready       = (state == ST_IDLE) && rst;
  assign bus.opd_valid      = (state == ST_HOLD);
  assign bus.opd_a          = opd_a_q;
  assign bus.opd_b          = opd_b_q;
  assign bus.opd_d          = opd_d_q;
  assign bus.dbg_state      = state;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.op_valid && bus.op_ready) state_nxt = ST_READ;
      ST_READ: if (sample)                       state_nxt = ST_WAIT;
      ST_WAIT:                                   state_nxt = ST_HOLD;
      ST_HOLD: if (bus.opd_ready)                state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src1_q     <= '0;
      src2_q     <= '0;
      srcd_q     <= '0;
      use_srcd_q <= 1'b0;
      last_d_q   <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
      opd_a_q    <= '0;
      opd_b_q    <= '0;
      opd_d_q    <= '0;
      starve_q   <= '0;
    end else begin
      last_d_q <= addr_data;
      if (state == ST_IDLE && bus.op_valid) begin
        src1_q     <= bus.op_src1;
        src2_q     <= bus.op_src2;
        srcd_q     <= bus.op_srcd;
        use_srcd_q <= bus.op_use_srcd;
      end
      // The file returns the pre-write value for a same-cycle write, so the
      // written value is captured here and substituted in WAIT.
      if (sample) begin
        byp1_q     <= bus.rf_enable && (addr_data == src1_q);
        byp2_q     <= bus.rf_enable && (addr_data == src2_q);
        byp_data_q <= data_in;
      end
      if (state == ST_WAIT) begin
        opd_a_q <= byp1_q ? byp_data_q : bus.rf_data1;
        opd_b_q <= byp2_q ? byp_data_q : bus.rf_data2;
        opd_d_q <= use_srcd_q ? bus.rf_dataMemory : '0;
      end
      if (read_slot)
        starve_q <= '0;
      else if (need_srcd && bus.rf_enable && starve_q != '1)
        starve_q <= starve_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scheduler.sv
// Bench for regfile_scheduler: register-file model with registered reads,
// architectural register image as the reference, scenario tasks.
module tb_regfile_scheduler;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_scheduler_if bus();

  regfile_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file: writes and reads on the same edge, reads see old data.
  data_t rf_mem [REG_COUNT];
  // Architectural image: value each register must hold after the writes
  // the bench expects to have been committed.
  data_t arch [REG_COUNT];

  always @(posedge clk) begin
    if (bus.rf_enable) rf_mem[bus.rf_addressData] <= bus.rf_dataIn;
    bus.rf_data1      <= rf_mem[bus.rf_address1];
    bus.rf_data2      <= rf_mem[bus.rf_address2];
    bus.rf_dataMemory <= rf_mem[bus.rf_addressData];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic load_reg(input reg_addr_t a, input data_t d);
    int n;
    n = 0;
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_addr  = a;
    bus.alu_wb_data  = d;
    #1;
    while (!bus.alu_wb_ready && n < 10) begin tick(); n++; end
    if (n >= 10) begin checks++; errors++; $display("FAIL load_reg_timeout reg=%0d", a); end
    tick();
    arch[a] = d;
    bus.alu_wb_valid = 1'b0;
  endtask

  // Returns #1 after the acceptance edge (scheduler is then in READ).
  task automatic issue(input reg_addr_t s1, input reg_addr_t s2, input reg_addr_t sd, input logic use_d);
    int n;
    n = 0;
    bus.op_valid    = 1'b1;
    bus.op_src1     = s1;
    bus.op_src2     = s2;
    bus.op_srcd     = sd;
    bus.op_use_srcd = use_d;
    while (!bus.op_ready && n < 20) begin tick(); n++; end
    if (n >= 20) begin checks++; errors++; $display("FAIL issue_timeout op_ready never high"); end
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_opd(output int lat);
    lat = 0;
    while (!bus.opd_valid && lat < 30) begin tick(); lat++; end
  endtask

  task automatic consume();
    bus.opd_ready = 1'b1;
    tick();
    bus.opd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_addr  = 3'd1;
    bus.alu_wb_data  = 8'h55;
    bus.op_valid     = 1'b1;
    repeat (2) tick();
    checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL rst_op_ready got=%b exp=0", bus.op_ready); end
    checks++; if (bus.opd_valid !== 1'b0) begin errors++; $display("FAIL rst_opd_valid got=%b exp=0", bus.opd_valid); end
    checks++; if (bus.rf_enable !== 1'b0) begin errors++; $display("FAIL rst_rf_enable got=%b exp=0", bus.rf_enable); end
    checks++; if (bus.alu_wb_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%b exp=0", bus.alu_wb_ready); end
    checks++; if ({bus.opd_a, bus.opd_b, bus.opd_d} !== 24'h0) begin errors++; $display("FAIL rst_opd got=%h exp=0", {bus.opd_a, bus.opd_b, bus.opd_d}); end
    checks++; if ({bus.rf_address1, bus.rf_address2, bus.rf_addressData} !== 9'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", {bus.rf_address1, bus.rf_address2, bus.rf_addressData}); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); end
    bus.alu_wb_valid = 1'b0;
    bus.op_valid     = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL rst_release_op_ready got=%b exp=1", bus.op_ready); end
  endtask

  task automatic test_basic();
    load_reg(3'd2, 8'h11);
    load_reg(3'd5, 8'h22);
    issue(3'd2, 3'd5, 3'd0, 1'b0);
    checks++; if ({bus.rf_address1, bus.rf_address2} !== {3'd2, 3'd5}) begin errors++; $display("FAIL basic_addr got=%h exp=%h", {bus.rf_address1, bus.rf_address2}, {3'd2, 3'd5}); end
    checks++; if (bus.opd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_read got=%b exp=0", bus.opd_valid); end
    tick();
    checks++; if (bus.opd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_wait got=%b exp=0", bus.opd_valid); end
    tick();
    checks++; if (bus.opd_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", bus.opd_valid); end
    checks++; if (bus.opd_a !== 8'h11) begin errors++; $display("FAIL basic_opd_a got=%h exp=11", bus.opd_a); end
    checks++; if (bus.opd_b !== 8'h22) begin errors++; $display("FAIL basic_opd_b got=%h exp=22", bus.opd_b); end
    checks++; if (bus.opd_d !== 8'h00) begin errors++; $display("FAIL basic_opd_d got=%h exp=00", bus.opd_d); end
    consume();
  endtask

  task automatic test_bypass();
    int lat;
    issue(3'd3, 3'd1, 3'd0, 1'b0);
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_addr  = 3'd3;
    bus.alu_wb_data  = 8'h7F;
    #1;
    checks++; if (bus.alu_wb_ready !== 1'b1) begin errors++; $display("FAIL bypass_grant got=%b exp=1", bus.alu_wb_ready); end
    arch[3] = 8'h7F;
    tick();
    bus.alu_wb_valid = 1'b0;
    tick();
    checks++; if (bus.opd_a !== 8'h7F) begin errors++; $display("FAIL bypass_opd_a got=%h exp=7f", bus.opd_a); end
    checks++; if (bus.opd_b !== arch[1]) begin errors++; $display("FAIL bypass_opd_b got=%h exp=%h", bus.opd_b, arch[1]); end
    consume();
    issue(3'd3, 3'd3, 3'd0, 1'b0);
    wait_opd(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL bypass_later_latency got=%0d exp=2", lat); end
    checks++; if ({bus.opd_a, bus.opd_b} !== 16'h7F7F) begin errors++; $display("FAIL bypass_later_read got=%h exp=7f7f", {bus.opd_a, bus.opd_b}); end
    consume();
  endtask

  task automatic test_round_robin();
    reg_addr_t aa, ma;
    data_t     ad, md;
    logic      exp_alu;
    do_reset();
    aa = reg_addr_t'($urandom_range(0, 7)); ad = data_t'($urandom_range(0, 255));
    ma = reg_addr_t'($urandom_range(0, 7)); md = data_t'($urandom_range(0, 255));
    exp_alu = 1'b1;
    bus.alu_wb_valid = 1'b1;
    bus.mem_wb_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.alu_wb_addr = aa; bus.alu_wb_data = ad;
      bus.mem_wb_addr = ma; bus.mem_wb_data = md;
      #1;
      checks++; if ({bus.rf_enable, bus.alu_wb_ready, bus.mem_wb_ready} !== {1'b1, exp_alu, !exp_alu}) begin errors++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, {bus.rf_enable, bus.alu_wb_ready, bus.mem_wb_ready}, {1'b1, exp_alu, !exp_alu}); end
      checks++; if ({bus.rf_addressData, bus.rf_dataIn} !== (exp_alu ? {aa, ad} : {ma, md})) begin errors++; $display("FAIL rr_payload cyc=%0d got=%h exp=%h", c, {bus.rf_addressData, bus.rf_dataIn}, exp_alu ? {aa, ad} : {ma, md}); end
      if (exp_alu) begin
        arch[aa] = ad;
        aa = reg_addr_t'($urandom_range(0, 7)); ad = data_t'($urandom_range(0, 255));
      end else begin
        arch[ma] = md;
        ma = reg_addr_t'($urandom_range(0, 7)); md = data_t'($urandom_range(0, 255));
      end
      exp_alu = !exp_alu;
      tick();
    end
    bus.alu_wb_valid = 1'b0;
    bus.mem_wb_valid = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) begin
      checks++; if (rf_mem[i] !== arch[i]) begin errors++; $display("FAIL rr_file reg=%0d got=%h exp=%h", i, rf_mem[i], arch[i]); end
    end
  endtask

  task automatic test_starve();
    reg_addr_t aa, ma;
    data_t     ad, md;
    logic      exp_alu;
    do_reset();
    issue(3'd0, 3'd1, 3'd4, 1'b1);
    aa = reg_addr_t'($urandom_range(0, 3)); ad = data_t'($urandom_range(0, 255));
    ma = reg_addr_t'($urandom_range(0, 3)); md = data_t'($urandom_range(0, 255));
    exp_alu = 1'b1;
    bus.alu_wb_valid = 1'b1;
    bus.mem_wb_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.alu_wb_addr = aa; bus.alu_wb_data = ad;
      bus.mem_wb_addr = ma; bus.mem_wb_data = md;
      #1;
      if (c < 4) begin
        checks++; if ({bus.rf_enable, bus.alu_wb_ready, bus.mem_wb_ready} !== {1'b1, exp_alu, !exp_alu}) begin errors++; $display("FAIL starve_grant cyc=%0d got=%b exp=%b", c, {bus.rf_enable, bus.alu_wb_ready, bus.mem_wb_ready}, {1'b1, exp_alu, !exp_alu}); end
        if (exp_alu) begin
          arch[aa] = ad;
          aa = reg_addr_t'($urandom_range(0, 3)); ad = data_t'($urandom_range(0, 255));
        end else begin
          arch[ma] = md;
          ma = reg_addr_t'($urandom_range(0, 3)); md = data_t'($urandom_range(0, 255));
        end
        exp_alu = !exp_alu;
      end else begin
        checks++; if ({bus.rf_enable, bus.alu_wb_ready, bus.mem_wb_ready} !== 3'b000) begin errors++; $display("FAIL starve_read_slot got=%b exp=000", {bus.rf_enable, bus.alu_wb_ready, bus.mem_wb_ready}); end
        checks++; if (bus.rf_addressData !== 3'd4) begin errors++; $display("FAIL starve_read_addr got=%0d exp=4", bus.rf_addressData); end
      end
      tick();
    end
    bus.alu_wb_valid = 1'b0;
    bus.mem_wb_valid = 1'b0;
    tick();
    checks++; if (bus.opd_valid !== 1'b1) begin errors++; $display("FAIL starve_opd_valid got=%b exp=1", bus.opd_valid); end
    checks++; if ({bus.opd_a, bus.opd_b, bus.opd_d} !== {arch[0], arch[1], arch[4]}) begin errors++; $display("FAIL starve_operands got=%h exp=%h", {bus.opd_a, bus.opd_b, bus.opd_d}, {arch[0], arch[1], arch[4]}); end
    consume();
  endtask

  task automatic test_hold();
    int lat;
    issue(3'd6, 3'd7, 3'd2, 1'b1);
    wait_opd(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL hold_latency got=%0d exp=2", lat); end
    for (int c = 0; c < 5; c++) begin
      checks++; if ({bus.opd_valid, bus.op_ready} !== 2'b10) begin errors++; $display("FAIL hold_flags cyc=%0d got=%b exp=10", c, {bus.opd_valid, bus.op_ready}); end
      checks++; if ({bus.opd_a, bus.opd_b, bus.opd_d} !== {arch[6], arch[7], arch[2]}) begin errors++; $display("FAIL hold_stable cyc=%0d got=%h exp=%h", c, {bus.opd_a, bus.opd_b, bus.opd_d}, {arch[6], arch[7], arch[2]}); end
      tick();
    end
    consume();
    checks++; if ({bus.opd_valid, bus.op_ready} !== 2'b01) begin errors++; $display("FAIL hold_release got=%b exp=01", {bus.opd_valid, bus.op_ready}); end
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(3'd1, 3'd2, 3'd0, 1'b0);
    tick();
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_addr  = 3'd5;
    bus.alu_wb_data  = 8'hA5;
    #1;
    rst = 1'b0;
    #1;
    checks++; if ({bus.opd_valid, bus.rf_enable, bus.alu_wb_ready, bus.op_ready} !== 4'b0000) begin errors++; $display("FAIL midrst_outputs got=%b exp=0000", {bus.opd_valid, bus.rf_enable, bus.alu_wb_ready, bus.op_ready}); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE); end
    bus.alu_wb_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (rf_mem[5] !== arch[5]) begin errors++; $display("FAIL midrst_no_write got=%h exp=%h", rf_mem[5], arch[5]); end
    issue(3'd1, 3'd2, 3'd0, 1'b0);
    wait_opd(lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL midrst_latency got=%0d exp=2", lat); end
    checks++; if ({bus.opd_a, bus.opd_b} !== {arch[1], arch[2]}) begin errors++; $display("FAIL midrst_operands got=%h exp=%h", {bus.opd_a, bus.opd_b}, {arch[1], arch[2]}); end
    consume();
  endtask

  task automatic test_random();
    reg_addr_t s1, s2, sd, wa;
    data_t     wd, ea, eb, ed;
    logic      use_d;
    int        n;
    for (int t = 0; t < 20; t++) begin
      s1 = reg_addr_t'($urandom_range(0, 7));
      s2 = reg_addr_t'($urandom_range(0, 7));
      sd = reg_addr_t'($urandom_range(0, 7));
      use_d = 1'($urandom_range(0, 1));
      issue(s1, s2, sd, use_d);
      if (!use_d && $urandom_range(0, 1) == 1) begin
        wa = reg_addr_t'($urandom_range(0, 7));
        wd = data_t'($urandom_range(0, 255));
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = wa;
        bus.alu_wb_data  = wd;
        #1;
        checks++; if (bus.alu_wb_ready !== 1'b1) begin errors++; $display("FAIL rand_wb_grant t=%0d got=%b exp=1", t, bus.alu_wb_ready); end
        arch[wa] = wd;
      end
      // Operands reflect every write committed up to the sampling cycle.
      ea = arch[s1];
      eb = arch[s2];
      ed = use_d ? arch[sd] : 8'h00;
      tick();
      bus.alu_wb_valid = 1'b0;
      n = 0;
      while (!bus.opd_valid && n < 10) begin tick(); n++; end
      checks++; if (bus.opd_valid !== 1'b1) begin errors++; $display("FAIL rand_timeout t=%0d opd_valid=%b", t, bus.opd_valid); end
      checks++; if ({bus.opd_a, bus.opd_b, bus.opd_d} !== {ea, eb, ed}) begin errors++; $display("FAIL rand_operands t=%0d got=%h exp=%h", t, {bus.opd_a, bus.opd_b, bus.opd_d}, {ea, eb, ed}); end
      repeat ($urandom_range(0, 2)) tick();
      consume();
    end
  endtask

  initial begin
    bus.op_valid     = 1'b0;
    bus.op_src1      = '0;
    bus.op_src2      = '0;
    bus.op_srcd      = '0;
    bus.op_use_srcd  = 1'b0;
    bus.opd_ready    = 1'b0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_addr  = '0;
    bus.alu_wb_data  = '0;
    bus.mem_wb_valid = 1'b0;
    bus.mem_wb_addr  = '0;
    bus.mem_wb_data  = '0;
    test_reset();
    for (int i = 0; i < REG_COUNT; i++) load_reg(reg_addr_t'(i), data_t'($urandom_range(0, 255)));
    test_basic();
    test_bypass();
    test_round_robin();
    test_starve();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
